hash_bcd_engine: RTL

//  Parametrised hash/display core: debounces a run button, advances a keyed hash every

---
 rtl/hash_bcd_engine.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/hash_bcd_engine.sv
// Keyed hash display core: debounced run toggle, periodic hash update and a
// sequential double-dabble converter feeding a packed BCD digit bus.
module hash_bcd_engine #(
    parameter int unsigned WIDTH           = 16,
    parameter int unsigned N_DIGITS        = 5,
    parameter int unsigned MULT            = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned TICK_CYCLES     = 40
) (
    input  logic                  sysclk,
    input  logic                  rst_n,
    input  logic                  button_in,
    input  logic [WIDTH-1:0]      student_id,
    input  logic                  clear,
    output logic                  run,
    output logic [WIDTH-1:0]      hash_out,
    output logic                  busy,
    output logic [4*N_DIGITS-1:0] digits_out,
    output logic                  digits_valid,
    output logic                  ovf
);

    localparam int unsigned BCD_W  = 4 * N_DIGITS;
    localparam int unsigned DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned TICK_W = $clog2(TICK_CYCLES);
    localparam int unsigned BIT_W  = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Button path
    logic              btn_meta_q, btn_sync_q;
    logic              deb_level_q, deb_level_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic              run_q, run_d;

    // Tick and hash
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              tick;
    logic              tick_eff;
    logic [WIDTH-1:0]  hash_q, hash_d;
    logic [WIDTH-1:0]  hash_mul;
    logic [WIDTH-1:0]  hash_next;

    // Converter
    state_t            state_q, state_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic [BCD_W-1:0]  bcd_adj;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              ovf_acc_q, ovf_acc_d;
    logic [BCD_W-1:0]  digits_q, digits_d;
    logic              ovf_q, ovf_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;

    function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int k = 0; k < int'(N_DIGITS); k++) begin
            if (v[4*k +: 4] >= 4'd5) begin
                r[4*k +: 4] = v[4*k +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Debounce: level follows the synchronised input after enough differing samples
    always_comb begin
        deb_cnt_d   = '0;
        deb_level_d = deb_level_q;
        if (btn_sync_q != deb_level_q) begin
            if (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                deb_level_d = btn_sync_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
        run_d = run_q ^ (deb_level_d & ~deb_level_q);
    end

    // Tick generator and hash update
    always_comb begin
        tick       = 1'b0;
        tick_cnt_d = tick_cnt_q;
        if (!run_q) begin
            tick_cnt_d = '0;
        end else if (tick_cnt_q == TICK_W'(TICK_CYCLES - 1)) begin
            tick       = 1'b1;
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
        end
    end

    assign tick_eff  = tick & ~clear;
    assign hash_mul  = hash_q * WIDTH'(MULT);
    assign hash_next = hash_mul + student_id;
    assign bcd_adj   = dd_adjust(bcd_q);

    always_comb begin
        hash_d = hash_q;
        if (clear) begin
            hash_d = '0;
        end else if (tick) begin
            hash_d = hash_next;
        end
    end

    // Converter next-state and outputs; a tick restarts from any state
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bcd_d     = bcd_q;
        bit_cnt_d = bit_cnt_q;
        ovf_acc_d = ovf_acc_q;
        digits_d  = digits_q;
        ovf_d     = ovf_q;
        valid_d   = 1'b0;

        if (clear) begin
            state_d  = S_IDLE;
            digits_d = '0;
            ovf_d    = 1'b0;
        end else if (tick_eff) begin
            state_d   = S_SHIFT;
            shreg_d   = hash_next;
            bcd_d     = '0;
            bit_cnt_d = '0;
            ovf_acc_d = 1'b0;
        end else begin
            unique case (state_q)
                S_SHIFT: begin
                    bcd_d     = {bcd_adj[BCD_W-2:0], shreg_q[WIDTH-1]};
                    shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
                    ovf_acc_d = ovf_acc_q | bcd_adj[BCD_W-1];
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == BIT_W'(WIDTH - 1)) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    digits_d = bcd_q;
                    ovf_d    = ovf_acc_q;
                    valid_d  = 1'b1;
                    state_d  = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta_q  <= 1'b0;
            btn_sync_q  <= 1'b0;
            deb_level_q <= 1'b0;
            deb_cnt_q   <= '0;
            run_q       <= 1'b0;
            tick_cnt_q  <= '0;
            hash_q      <= '0;
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            bcd_q       <= '0;
            bit_cnt_q   <= '0;
            ovf_acc_q   <= 1'b0;
            digits_q    <= '0;
            ovf_q       <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            btn_meta_q  <= button_in;
            btn_sync_q  <= btn_meta_q;
            deb_level_q <= deb_level_d;
            deb_cnt_q   <= deb_cnt_d;
            run_q       <= run_d;
            tick_cnt_q  <= tick_cnt_d;
            hash_q      <= hash_d;
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bcd_q       <= bcd_d;
            bit_cnt_q   <= bit_cnt_d;
            ovf_acc_q   <= ovf_acc_d;
            digits_q    <= digits_d;
            ovf_q       <= ovf_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
        end
    end

    assign run          = run_q;
    assign hash_out     = hash_q;
    assign busy         = busy_q;
    assign digits_out   = digits_q;
    assign digits_valid = valid_q;
    assign ovf          = ovf_q;

endmodule
